// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the decode/execute issue scheduler.
package hazard_pkg;
    localparam int REG_W  = 5;
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             is_load;
    } slot_t;

    typedef enum logic {RUN, FLUSH} fsm_t;
endpackage

// File: rtl/hazard_match.sv
// hazard_match: compares one source register against every scoreboard slot and
// priority-encodes the newest matching producer into a forward select.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int SELW  = 2
) (
    input  logic [REG_W-1:0]  rs_i,
    input  slot_t [DEPTH-1:0] slots_i,
    output logic [DEPTH-1:0]  match_o,
    output logic [SELW-1:0]   sel_o,
    output logic              ld_hit_o
);
    logic [DEPTH-1:0] ld_v;

    // Walk oldest to newest so the lowest slot index (newest producer) wins.
    always_comb begin
        match_o = '0;
        ld_v    = '0;
        sel_o   = SELW'(FWD_RF);
        for (int k = DEPTH - 1; k >= 0; k--) begin
            match_o[k] = slots_i[k].valid && (rs_i != '0) && (slots_i[k].rd == rs_i);
            ld_v[k]    = slots_i[k].is_load;
            sel_o      = (slots_i[k].valid && (rs_i != '0) && (slots_i[k].rd == rs_i)) ? SELW'(k + 1) : sel_o;
        end
    end

    // Only a load still in EXE cannot be forwarded in time.
    assign ld_hit_o = |(match_o & ld_v & DEPTH'(1));
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-to-execute issue scheduler with a shift-register scoreboard,
// RAW stall / forward-select generation and a post-redirect flush window.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int FWD_EN       = 0,
    parameter int FLUSH_CYCLES = 1,
    parameter int SELW         = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid_i,
    input  logic [REG_W-1:0] dec_rs1_i,
    input  logic [REG_W-1:0] dec_rs2_i,
    input  logic [REG_W-1:0] dec_rd_i,
    input  logic             dec_is_load_i,
    input  logic             flush_from_exe,
    output logic             issue_o,
    output logic             stall_o,
    output logic [SELW-1:0]  fwd_rs1_sel_o,
    output logic [SELW-1:0]  fwd_rs2_sel_o,
    output logic             flush_state_o,
    output logic [31:0]      stall_cnt_o
);
    localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYCLES - 1);

    slot_t [DEPTH-1:0] slot_q, slot_d;
    fsm_t              fsm_q, fsm_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       stall_cnt_q, stall_cnt_d;
    logic [DEPTH-1:0]  m1, m2;
    logic [SELW-1:0]   sel1, sel2;
    logic              ld1, ld2, hazard, run;

    hazard_match #(.DEPTH(DEPTH), .SELW(SELW)) u_rs1 (
        .rs_i(dec_rs1_i), .slots_i(slot_q), .match_o(m1), .sel_o(sel1), .ld_hit_o(ld1)
    );
    hazard_match #(.DEPTH(DEPTH), .SELW(SELW)) u_rs2 (
        .rs_i(dec_rs2_i), .slots_i(slot_q), .match_o(m2), .sel_o(sel2), .ld_hit_o(ld2)
    );

    always_comb begin
        run           = (fsm_q == RUN);
        hazard        = dec_valid_i && ((FWD_EN != 0) ? (ld1 || ld2) : (|m1 || |m2));
        issue_o       = !rst && dec_valid_i && !hazard && run && !flush_from_exe;
        stall_o       = !rst && hazard && run && !flush_from_exe;
        fwd_rs1_sel_o = ((FWD_EN != 0) && issue_o) ? sel1 : SELW'(FWD_RF);
        fwd_rs2_sel_o = ((FWD_EN != 0) && issue_o) ? sel2 : SELW'(FWD_RF);
        flush_state_o = (fsm_q == FLUSH);
        stall_cnt_o   = stall_cnt_q;
    end

    // rd=0 never enters the scoreboard; stalls and flushes shift in bubbles.
    always_comb begin
        slot_d    = slot_q;
        slot_d[0] = (issue_o && dec_rd_i != '0) ? '{valid: 1'b1, rd: dec_rd_i, is_load: dec_is_load_i} : '0;
        for (int k = 1; k < DEPTH; k++) slot_d[k] = slot_q[k-1];
    end

    always_comb begin
        fsm_d       = fsm_q;
        cnt_d       = cnt_q;
        stall_cnt_d = (stall_o && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
        if (flush_from_exe) begin
            fsm_d = FLUSH;
            cnt_d = FLUSH_LD;
        end else if (fsm_q == FLUSH) begin
            fsm_d = (cnt_q == '0) ? RUN : FLUSH;
            cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q      <= '0;
            fsm_q       <= RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            slot_q      <= slot_d;
            fsm_q       <= fsm_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of stall, forwarding, load-use, flush and reset
// behaviour on an interlock-only instance (dut0) and a forwarding instance (dut1).
module tb_hazard_ctrl;
    logic       clk = 0, rst = 0, v = 0, ld = 0, fl = 0;
    logic [4:0] rs1 = 0, rs2 = 0, rd = 0;
    logic       issue0, stall0, fst0, issue1, stall1, fst1;
    logic [1:0] s10, s20, s11, s21;
    logic [31:0] cnt0, cnt1;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.DEPTH(2), .FWD_EN(0), .FLUSH_CYCLES(2), .SELW(2)) dut0 (
        .clk(clk), .rst(rst), .dec_valid_i(v), .dec_rs1_i(rs1), .dec_rs2_i(rs2),
        .dec_rd_i(rd), .dec_is_load_i(ld), .flush_from_exe(fl), .issue_o(issue0),
        .stall_o(stall0), .fwd_rs1_sel_o(s10), .fwd_rs2_sel_o(s20),
        .flush_state_o(fst0), .stall_cnt_o(cnt0)
    );
    hazard_ctrl #(.DEPTH(2), .FWD_EN(1), .FLUSH_CYCLES(2), .SELW(2)) dut1 (
        .clk(clk), .rst(rst), .dec_valid_i(v), .dec_rs1_i(rs1), .dec_rs2_i(rs2),
        .dec_rd_i(rd), .dec_is_load_i(ld), .flush_from_exe(fl), .issue_o(issue1),
        .stall_o(stall1), .fwd_rs1_sel_o(s11), .fwd_rs2_sel_o(s21),
        .flush_state_o(fst1), .stall_cnt_o(cnt1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vv, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input logic l, input logic f);
        v = vv; rs1 = a; rs2 = b; rd = d; ld = l; fl = f;
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (cnt0 !== 32'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", cnt0); end
        checks++; if (fst0 !== 1'b0) begin errors++; $display("FAIL rst_fst got %0b exp 0", fst0); end
        drive(1, 0, 0, 5, 0, 0);
        tick();
        drive(1, 0, 0, 6, 0, 0);
        tick();
        drive(1, 6, 0, 0, 0, 0);
        checks++; if (stall0 !== 1'b1) begin errors++; $display("FAIL rst_pre_stall got %0b exp 1", stall0); end
        tick();
        checks++; if (cnt0 !== 32'd1) begin errors++; $display("FAIL rst_pre_cnt got %0d exp 1", cnt0); end
        rst = 1;
        #1;
        checks++; if ({issue0, stall0, s10, s20} !== 6'b0) begin errors++; $display("FAIL rst_outs0 got %b exp 000000", {issue0, stall0, s10, s20}); end
        checks++; if ({issue1, stall1, s11, s21} !== 6'b0) begin errors++; $display("FAIL rst_outs1 got %b exp 000000", {issue1, stall1, s11, s21}); end
        tick();
        rst = 0;
        #1;
        checks++; if (cnt0 !== 32'd0) begin errors++; $display("FAIL rst_post_cnt got %0d exp 0", cnt0); end
        checks++; if (issue0 !== 1'b1 || stall0 !== 1'b0) begin errors++; $display("FAIL rst_post_issue got %b exp 10", {issue0, stall0}); end
        checks++; if (fst0 !== 1'b0) begin errors++; $display("FAIL rst_post_fst got %0b exp 0", fst0); end
    endtask

    task automatic test_raw_stall();
        do_reset();
        drive(1, 0, 0, 5, 0, 0);
        checks++; if (issue0 !== 1'b1) begin errors++; $display("FAIL raw_prod got %0b exp 1", issue0); end
        tick();
        drive(1, 5, 0, 8, 0, 0);
        checks++; if ({issue0, stall0} !== 2'b01) begin errors++; $display("FAIL raw_stall1 got %b exp 01", {issue0, stall0}); end
        checks++; if (s10 !== 2'd0) begin errors++; $display("FAIL raw_sel got %0d exp 0", s10); end
        tick();
        checks++; if ({issue0, stall0} !== 2'b01) begin errors++; $display("FAIL raw_stall2 got %b exp 01", {issue0, stall0}); end
        tick();
        checks++; if ({issue0, stall0} !== 2'b10) begin errors++; $display("FAIL raw_issue got %b exp 10", {issue0, stall0}); end
        checks++; if (cnt0 !== 32'd2) begin errors++; $display("FAIL raw_cnt got %0d exp 2", cnt0); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_forward();
        do_reset();
        drive(1, 0, 0, 5, 0, 0);
        tick();
        drive(1, 5, 5, 9, 0, 0);
        checks++; if ({issue1, stall1} !== 2'b10) begin errors++; $display("FAIL fwd_nostall got %b exp 10", {issue1, stall1}); end
        checks++; if (s11 !== 2'd1 || s21 !== 2'd1) begin errors++; $display("FAIL fwd_sel1 got %0d/%0d exp 1/1", s11, s21); end
        tick();
        drive(1, 9, 5, 0, 0, 0);
        checks++; if (s11 !== 2'd1 || s21 !== 2'd2) begin errors++; $display("FAIL fwd_sel2 got %0d/%0d exp 1/2", s11, s21); end
        tick();
        drive(1, 9, 0, 0, 0, 0);
        checks++; if (s11 !== 2'd2 || s21 !== 2'd0) begin errors++; $display("FAIL fwd_sel3 got %0d/%0d exp 2/0", s11, s21); end
        tick();
        drive(1, 5, 0, 5, 0, 0);
        tick();
        drive(1, 5, 0, 5, 0, 0);
        tick();
        drive(1, 0, 5, 0, 0, 0);
        checks++; if (s21 !== 2'd1) begin errors++; $display("FAIL fwd_newest got %0d exp 1", s21); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 0, 0, 7, 1, 0);
        tick();
        drive(1, 7, 0, 0, 0, 0);
        checks++; if ({issue1, stall1} !== 2'b01) begin errors++; $display("FAIL lu_stall got %b exp 01", {issue1, stall1}); end
        checks++; if (s11 !== 2'd0) begin errors++; $display("FAIL lu_sel_stall got %0d exp 0", s11); end
        tick();
        checks++; if ({issue1, stall1} !== 2'b10) begin errors++; $display("FAIL lu_issue got %b exp 10", {issue1, stall1}); end
        checks++; if (s11 !== 2'd2) begin errors++; $display("FAIL lu_sel got %0d exp 2", s11); end
        checks++; if (cnt1 !== 32'd1) begin errors++; $display("FAIL lu_cnt got %0d exp 1", cnt1); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 0, 0, 5, 0, 0);
        tick();
        drive(1, 5, 0, 0, 0, 1);
        checks++; if ({issue0, stall0} !== 2'b00) begin errors++; $display("FAIL fl_prio got %b exp 00", {issue0, stall0}); end
        tick();
        drive(1, 5, 0, 0, 0, 0);
        checks++; if (fst0 !== 1'b1 || issue0 !== 1'b0 || stall0 !== 1'b0) begin errors++; $display("FAIL fl_c1 got %b exp 100", {fst0, issue0, stall0}); end
        tick();
        checks++; if (fst0 !== 1'b1) begin errors++; $display("FAIL fl_c2 got %0b exp 1", fst0); end
        drive(1, 5, 0, 0, 0, 1);
        tick();
        drive(1, 5, 0, 0, 0, 0);
        checks++; if (fst0 !== 1'b1 || issue0 !== 1'b0) begin errors++; $display("FAIL fl_ext1 got %b exp 10", {fst0, issue0}); end
        tick();
        checks++; if (fst0 !== 1'b1) begin errors++; $display("FAIL fl_ext2 got %0b exp 1", fst0); end
        tick();
        checks++; if (fst0 !== 1'b0 || issue0 !== 1'b1) begin errors++; $display("FAIL fl_exit got %b exp 01", {fst0, issue0}); end
        checks++; if (cnt0 !== 32'd0) begin errors++; $display("FAIL fl_cnt got %0d exp 0", cnt0); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_zero_regs();
        do_reset();
        drive(1, 0, 0, 0, 1, 0);
        checks++; if (issue0 !== 1'b1) begin errors++; $display("FAIL z_prod got %0b exp 1", issue0); end
        tick();
        drive(1, 0, 0, 0, 0, 0);
        checks++; if ({issue0, stall0, issue1, stall1} !== 4'b1010) begin errors++; $display("FAIL z_cons1 got %b exp 1010", {issue0, stall0, issue1, stall1}); end
        checks++; if ({s11, s21} !== 4'b0) begin errors++; $display("FAIL z_sel got %b exp 0000", {s11, s21}); end
        tick();
        checks++; if ({issue0, stall0} !== 2'b10) begin errors++; $display("FAIL z_cons2 got %b exp 10", {issue0, stall0}); end
        checks++; if (cnt0 !== 32'd0 || cnt1 !== 32'd0) begin errors++; $display("FAIL z_cnt got %0d/%0d exp 0/0", cnt0, cnt1); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_raw_stall();
        test_forward();
        test_load_use();
        test_flush();
        test_zero_regs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
hazard_ctrl is the issue scheduler between decode and execute in the RV32I_X pipeline. It tracks destination registers of in-flight instructions in a shift-register scoreboard, one slot per post-decode stage. From that scoreboard it decides each cycle whether the decoded instruction may issue, must stall, or is killed by a branch flush. With forwarding enabled, it also drives operand-forward selects to execute.

Parameters:
DEPTH, 2, number of in-flight stages tracked after decode (slot0 = EXE, slot DEPTH-1 = last stage before regfile write-through); legal range 1-4
FWD_EN, 0, 0 = stall on any RAW match; 1 = forward from slots, stall only on load-use
FLUSH_CYCLES, 1, cycles issue stays suppressed after a flush; legal range 1-15
SELW, 2, width of forward selects; must equal clog2(DEPTH+1)

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous reset, active-high
dec_valid_i  in  1  decode holds a valid instruction
dec_rs1_i  in  5  source register 1 (0 = unused)
dec_rs2_i  in  5  source register 2 (0 = unused)
dec_rd_i  in  5  destination register (0 = none)
dec_is_load_i  in  1  instruction is LB/LH/LW/LBU/LHU
flush_from_exe  in  1  branch/jump redirect from execute, single-cycle pulse
issue_o  out  1  instruction advances to EXE this cycle
stall_o  out  1  hold IF and decode registers
fwd_rs1_sel_o  out  SELW  0 = regfile, k+1 = forward from slot k
fwd_rs2_sel_o  out  SELW  same encoding for rs2
flush_state_o  out  1  1 while FSM is in FLUSH
stall_cnt_o  out  32  saturating count of stall cycles

Behaviour:
- Reset is synchronous and active-high on clk. In a cycle where rst=1: every slot invalid, FSM=RUN, flush counter=0, stall_cnt_o=0. issue_o, stall_o and both selects are forced to 0 that cycle.
- Slot fields: {valid, rd[4:0], is_load}. Every cycle, slot[k] <= slot[k-1] for k>=1.
  - slot0 <= {1, dec_rd_i, dec_is_load_i} when issue_o=1 and dec_rd_i!=0; otherwise slot0 <= bubble (valid=0).
  - The entry leaving slot[DEPTH-1] is retired; its value is covered by decode write-through.
- match_k(rs) = slot[k].valid & (rs!=0) & (slot[k].rd==rs).
- Hazard rules:
  - FWD_EN=0: hazard = dec_valid_i & any match_k(rs1 or rs2).
  - FWD_EN=1: hazard = dec_valid_i & (match_0(rs1|rs2) & slot0.is_load).
- Forward selects (FWD_EN=1 only): sel = 1 + smallest k with match_k, so the newest producer wins. sel = 0 if no match, if FWD_EN=0, or if issue_o=0.
- issue_o = dec_valid_i & ~hazard & (FSM==RUN) & ~flush_from_exe.
- stall_o = hazard & (FSM==RUN) & ~flush_from_exe. Flush has priority over a stall.
- issue_o, stall_o and the selects are combinational from inputs and registered state; all other state is registered.
- FSM:
  - RUN: on flush_from_exe go to FLUSH and load the counter with FLUSH_CYCLES-1.
  - FLUSH: issue suppressed, slot0 fills with bubbles. If cnt==0 and no new flush, go to RUN; else decrement.
  - A flush arriving while in FLUSH reloads the counter to FLUSH_CYCLES-1.
- On flush, slots 1..DEPTH-1 are not cleared (they hold older, committed instructions). Only the decode instruction is killed.
- stall_cnt_o increments by 1 each cycle stall_o=1 and holds at 0xFFFF_FFFF.
- Duplicate rd values across slots are legal. rd=0 is never recorded. Back-to-back stalls are unbounded and clear naturally as slots drain.

Decomposition:
- Package hazard_pkg:
  - slot_t struct {valid, rd[4:0], is_load}
  - fsm_t enum {RUN, FLUSH}
  - constant FWD_RF=0
  - constant REG_W=5
- One sub-module, hazard_match: combinational; takes rs and the slot array, returns the DEPTH-bit match vector plus the priority-encoded newest-match select. Instantiated once for rs1 and once for rs2.

Test Plan:
- FWD_EN=0, DEPTH=2: issue ADDI x5 (rd=5), then next cycle rs1=5 -> stall_o=1 for exactly 2 cycles; issue_o=1 on the 3rd; stall_cnt_o=2.
- FWD_EN=1: ADDI x5, then ADD rs1=5,rs2=5 next cycle -> no stall; fwd_rs1_sel_o=fwd_rs2_sel_o=1. One cycle later, rs2=5 -> sel=2.
- FWD_EN=1: LW x7, then consumer rs1=7 -> stall_o=1 for 1 cycle; then issue with fwd_rs1_sel_o=2.
- Stalled consumer plus flush_from_exe=1 in the same cycle, FLUSH_CYCLES=2 -> issue_o=0, stall_o=0; flush_state_o=1 for 2 cycles; a second flush mid-FLUSH extends it to 2 more cycles.
- rd=0 / rs=0: instructions with rd=0, then consumers with rs1=0 -> never stall; no slot becomes valid.
- Assert rst for 1 cycle with both slots valid and a stall pending -> next cycle slots empty, FSM=RUN, stall_cnt_o=0; a consumer issues immediately.
